// File: rtl/wakeup_sched_pkg.sv
// wakeup_sched_pkg: shared payload type, robIdx age compare and default sizes for wakeup_scheduler
package wakeup_sched_pkg;
  localparam int NUM_REQ_D = 4;
  localparam int NUM_PORT_D = 2;
  localparam int MAX_LAT_D = 3;
  localparam int PDEST_W = 6;
  localparam int ROB_W = 5;
  localparam int LAT_W = 2;
  typedef struct packed {
    logic rf_wen;
    logic fp_wen;
    logic [PDEST_W-1:0] pdest;
    logic rob_flag;
    logic [ROB_W-1:0] rob_value;
  } wakeup_bits_t;
  function automatic logic is_after(input wakeup_bits_t a, input logic r_flag, input logic [ROB_W-1:0] r_value);
    return (a.rob_flag != r_flag) ^ (a.rob_value > r_value);
  endfunction
endpackage

// File: rtl/wakeup_rr_arbiter.sv
// wakeup_rr_arbiter: grants up to NUM_PORT requests in round-robin order starting at rr_ptr
module wakeup_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_PORT = 2,
  parameter int PTR_W = 2
) (
  input  logic [NUM_REQ-1:0]                req,
  input  logic [PTR_W-1:0]                  rr_ptr,
  output logic [NUM_PORT-1:0][NUM_REQ-1:0]  grant,
  output logic [NUM_PORT-1:0]               port_valid,
  output logic [PTR_W-1:0]                  next_ptr
);
  // walk requesters upward from rr_ptr with wrap, handing out ports in order
  always_comb begin
    int idx;
    int n;
    grant = '0;
    port_valid = '0;
    next_ptr = rr_ptr;
    n = 0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx] && n < NUM_PORT) begin
        grant[n][idx] = 1'b1;
        port_valid[n] = 1'b1;
        next_ptr = PTR_W'((idx + 1) % NUM_REQ);
        n = n + 1;
      end
    end
  end
endmodule

// File: rtl/wakeup_scheduler.sv
// wakeup_scheduler: delayed wakeup slots with round-robin broadcast; WAKEUP_SCHED_PERF_EN adds io_perf_stall
module wakeup_scheduler
  import wakeup_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int NUM_PORT = NUM_PORT_D,
  parameter int MAX_LAT = MAX_LAT_D
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          io_req_valid,
  output logic [NUM_REQ-1:0]          io_req_ready,
  input  logic [NUM_REQ*LAT_W-1:0]    io_req_lat,
  input  logic [NUM_REQ-1:0]          io_req_rfWen,
  input  logic [NUM_REQ-1:0]          io_req_fpWen,
  input  logic [NUM_REQ*PDEST_W-1:0]  io_req_pdest,
  input  logic [NUM_REQ-1:0]          io_req_robIdx_flag,
  input  logic [NUM_REQ*ROB_W-1:0]    io_req_robIdx_value,
  input  logic                        io_redirect_valid,
  input  logic                        io_redirect_robIdx_flag,
  input  logic [ROB_W-1:0]            io_redirect_robIdx_value,
  output logic [NUM_PORT-1:0]         io_out_valid,
  output logic [NUM_PORT-1:0]         io_out_rfWen,
  output logic [NUM_PORT-1:0]         io_out_fpWen,
  output logic [NUM_PORT*PDEST_W-1:0] io_out_pdest,
  output logic [NUM_PORT-1:0]         io_out_robIdx_flag,
  output logic [NUM_PORT*ROB_W-1:0]   io_out_robIdx_value
`ifdef WAKEUP_SCHED_PERF_EN
  ,
  output logic [31:0]                 io_perf_stall
`endif
);
  localparam int PTR_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  wakeup_bits_t req_bits [NUM_REQ];
  wakeup_bits_t slot_bits [NUM_REQ];
  wakeup_bits_t sel_bits [NUM_PORT];
  wakeup_bits_t out_bits [NUM_PORT];
  logic [LAT_W-1:0] slot_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] slot_valid, kill, mature, drop, granted, fire;
  logic [NUM_PORT-1:0][NUM_REQ-1:0] grant;
  logic [NUM_PORT-1:0] port_valid;
  logic [PTR_W-1:0] rr_ptr, next_ptr;
  logic lat_ok;
  // decode requests, mark slots and incoming entries younger than the redirect
  always_comb begin
    lat_ok = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bits[i] = {io_req_rfWen[i], io_req_fpWen[i], io_req_pdest[i*PDEST_W +: PDEST_W],
                     io_req_robIdx_flag[i], io_req_robIdx_value[i*ROB_W +: ROB_W]};
      kill[i] = io_redirect_valid && slot_valid[i] &&
                is_after(slot_bits[i], io_redirect_robIdx_flag, io_redirect_robIdx_value);
      drop[i] = io_redirect_valid && is_after(req_bits[i], io_redirect_robIdx_flag, io_redirect_robIdx_value);
      mature[i] = slot_valid[i] && slot_cnt[i] == '0 && !kill[i];
      lat_ok &= !(io_req_valid[i] && {1'b0, io_req_lat[i*LAT_W +: LAT_W]} > (LAT_W+1)'(MAX_LAT));
    end
  end
  lat_legal: assert property (@(posedge clock) disable iff (reset) lat_ok);
  wakeup_rr_arbiter #(.NUM_REQ(NUM_REQ), .NUM_PORT(NUM_PORT), .PTR_W(PTR_W)) u_arb (
    .req(mature),
    .rr_ptr(rr_ptr),
    .grant(grant),
    .port_valid(port_valid),
    .next_ptr(next_ptr)
  );
  // a granted slot frees up in the same cycle, so it can take a new request back to back
  always_comb begin
    granted = '0;
    for (int p = 0; p < NUM_PORT; p++) granted |= grant[p];
    io_req_ready = ~slot_valid | granted;
    fire = io_req_valid & io_req_ready;
  end
  // route the one-hot granted slot payload to each port
  always_comb begin
    for (int p = 0; p < NUM_PORT; p++) begin
      sel_bits[p] = '0;
      for (int i = 0; i < NUM_REQ; i++) sel_bits[p] = wakeup_bits_t'(sel_bits[p] | (grant[p][i] ? slot_bits[i] : '0));
    end
  end
  // slot state: load on accepted request, clear on grant or kill, otherwise count down to maturity
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      slot_valid <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_cnt[i] <= '0;
        slot_bits[i] <= '0;
      end
    end else begin
      rr_ptr <= next_ptr;
      for (int i = 0; i < NUM_REQ; i++)
        if (fire[i] && !drop[i]) begin
          slot_valid[i] <= 1'b1;
          slot_cnt[i] <= io_req_lat[i*LAT_W +: LAT_W];
          slot_bits[i] <= req_bits[i];
        end else if (granted[i] || kill[i]) slot_valid[i] <= 1'b0;
        else if (slot_valid[i] && slot_cnt[i] != '0) slot_cnt[i] <= slot_cnt[i] - 1'b1;
    end
  // broadcast registers; a later redirect never retracts what is already out
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      io_out_valid <= '0;
      for (int p = 0; p < NUM_PORT; p++) out_bits[p] <= '0;
    end else begin
      io_out_valid <= port_valid;
      for (int p = 0; p < NUM_PORT; p++) out_bits[p] <= sel_bits[p];
    end
  // flatten registered payloads onto the port vectors
  always_comb begin
    for (int p = 0; p < NUM_PORT; p++) begin
      io_out_rfWen[p] = out_bits[p].rf_wen;
      io_out_fpWen[p] = out_bits[p].fp_wen;
      io_out_pdest[p*PDEST_W +: PDEST_W] = out_bits[p].pdest;
      io_out_robIdx_flag[p] = out_bits[p].rob_flag;
      io_out_robIdx_value[p*ROB_W +: ROB_W] = out_bits[p].rob_value;
    end
  end
`ifdef WAKEUP_SCHED_PERF_EN
  logic [32:0] stall_sum;
  assign stall_sum = {1'b0, io_perf_stall} + 33'($countones(mature & ~granted));
  // count mature slots that lost arbitration, saturating
  always_ff @(posedge clock or posedge reset)
    if (reset) io_perf_stall <= '0;
    else io_perf_stall <= stall_sum[32] ? '1 : stall_sum[31:0];
`endif
endmodule

// File: tb/tb_wakeup_scheduler.sv
// tb_wakeup_scheduler: directed checks of latency, round-robin, redirect kill and async reset
module tb_wakeup_scheduler;
  logic clock, reset;
  logic [3:0] req_valid, ready, req_rf, req_fp, req_flag;
  logic [7:0] req_lat;
  logic [23:0] req_pdest;
  logic [19:0] req_value;
  logic redir_valid, redir_flag;
  logic [4:0] redir_value;
  logic [1:0] out_valid, out_rf, out_fp, out_flag;
  logic [11:0] out_pdest;
  logic [9:0] out_value;
  logic [1:0] seen;
  int total = 0;
  int bad = 0;
`ifdef WAKEUP_SCHED_PERF_EN
  logic [31:0] perf_stall;
`endif

  wakeup_scheduler dut (
    .clock(clock),
    .reset(reset),
    .io_req_valid(req_valid),
    .io_req_ready(ready),
    .io_req_lat(req_lat),
    .io_req_rfWen(req_rf),
    .io_req_fpWen(req_fp),
    .io_req_pdest(req_pdest),
    .io_req_robIdx_flag(req_flag),
    .io_req_robIdx_value(req_value),
    .io_redirect_valid(redir_valid),
    .io_redirect_robIdx_flag(redir_flag),
    .io_redirect_robIdx_value(redir_value),
    .io_out_valid(out_valid),
    .io_out_rfWen(out_rf),
    .io_out_fpWen(out_fp),
    .io_out_pdest(out_pdest),
    .io_out_robIdx_flag(out_flag),
    .io_out_robIdx_value(out_value)
`ifdef WAKEUP_SCHED_PERF_EN
    ,
    .io_perf_stall(perf_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_lat = '0;
    req_rf = '0;
    req_fp = '0;
    req_pdest = '0;
    req_flag = '0;
    req_value = '0;
  endtask

  task automatic set_req(input int i, input logic [1:0] lat, input logic [5:0] pd, input logic fl, input logic [4:0] v);
    req_valid[i] = 1'b1;
    req_lat[i*2 +: 2] = lat;
    req_rf[i] = 1'b1;
    req_fp[i] = 1'b0;
    req_pdest[i*6 +: 6] = pd;
    req_flag[i] = fl;
    req_value[i*5 +: 5] = v;
  endtask

  task automatic do_reset();
    clear_reqs();
    redir_valid = 1'b0;
    redir_flag = 1'b0;
    redir_value = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_ready", 32'(ready), 32'hF);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pdest", 32'(out_pdest), 32'h0);
    // single lat-0 request: broadcast two cycles after acceptance
    step();
    step();
    set_req(2, 2'd0, 6'h15, 1'b0, 5'd1);
    chk("t1_ready_pre", 32'(ready[2]), 32'h1);
    step();
    clear_reqs();
    chk("t1_valid_early", 32'(out_valid), 32'h0);
    chk("t1_ready_grant", 32'(ready[2]), 32'h1);
    step();
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_pdest", 32'(out_pdest[5:0]), 32'h15);
    chk("t1_rf_fp", 32'({out_rf[0], out_fp[0]}), 32'h2);
    chk("t1_rob", 32'({out_flag[0], out_value[4:0]}), 32'h01);
    step();
    chk("t1_valid_after", 32'(out_valid), 32'h0);
    // all four lat 1 from rr_ptr 0: two ports per cycle
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'd1, 6'(6'h10 + i), 1'b0, 5'(i));
    step();
    clear_reqs();
    chk("t2_c1_valid", 32'(out_valid), 32'h0);
    step();
    chk("t2_c2_valid", 32'(out_valid), 32'h0);
    step();
    chk("t2_c3_valid", 32'(out_valid), 32'h3);
    chk("t2_c3_pdest", 32'(out_pdest), 32'({6'h11, 6'h10}));
    step();
    chk("t2_c4_valid", 32'(out_valid), 32'h3);
    chk("t2_c4_pdest", 32'(out_pdest), 32'({6'h13, 6'h12}));
    step();
    chk("t2_c5_valid", 32'(out_valid), 32'h0);
    // rr_ptr back at 0: requester 0 takes port 0 ahead of requester 3
    set_req(0, 2'd0, 6'h30, 1'b0, 5'd0);
    set_req(3, 2'd0, 6'h33, 1'b0, 5'd3);
    step();
    clear_reqs();
    step();
    chk("t2_rr_valid", 32'(out_valid), 32'h3);
    chk("t2_rr_pdest", 32'(out_pdest), 32'({6'h33, 6'h30}));
    // lat 3 slot blocks a second request until its grant cycle
    set_req(1, 2'd3, 6'h21, 1'b0, 5'd4);
    step();
    set_req(1, 2'd0, 6'h2A, 1'b0, 5'd5);
    chk("t3_ready_c1", 32'(ready[1]), 32'h0);
    step();
    chk("t3_ready_c2", 32'(ready[1]), 32'h0);
    step();
    chk("t3_ready_c3", 32'(ready[1]), 32'h0);
    chk("t3_valid_c3", 32'(out_valid), 32'h0);
    step();
    chk("t3_ready_grant", 32'(ready[1]), 32'h1);
    step();
    clear_reqs();
    chk("t3_first_valid", 32'(out_valid), 32'h1);
    chk("t3_first_pdest", 32'(out_pdest[5:0]), 32'h21);
    step();
    chk("t3_second_valid", 32'(out_valid), 32'h1);
    chk("t3_second_pdest", 32'(out_pdest[5:0]), 32'h2A);
    // redirect (0,5): kills slot (0,7) and incoming (0,9); (0,3) and equal (0,5) survive
    set_req(0, 2'd2, 6'h07, 1'b0, 5'd7);
    set_req(1, 2'd2, 6'h03, 1'b0, 5'd3);
    step();
    clear_reqs();
    redir_valid = 1'b1;
    redir_flag = 1'b0;
    redir_value = 5'd5;
    set_req(2, 2'd0, 6'h09, 1'b0, 5'd9);
    set_req(3, 2'd0, 6'h05, 1'b0, 5'd5);
    chk("t4_ready_redir", 32'(ready[3:2]), 32'h3);
    step();
    clear_reqs();
    redir_valid = 1'b0;
    chk("t4_c2_valid", 32'(out_valid), 32'h0);
    step();
    chk("t4_equal_valid", 32'(out_valid), 32'h1);
    chk("t4_equal_pdest", 32'(out_pdest[5:0]), 32'h05);
    step();
    chk("t4_older_valid", 32'(out_valid), 32'h1);
    chk("t4_older_pdest", 32'(out_pdest[5:0]), 32'h03);
    step();
    chk("t4_none_valid", 32'(out_valid), 32'h0);
    // redirect (1,2) against slot (0,30): slot is older and survives
    set_req(0, 2'd1, 6'h1E, 1'b0, 5'd30);
    step();
    clear_reqs();
    redir_valid = 1'b1;
    redir_flag = 1'b1;
    redir_value = 5'd2;
    step();
    redir_valid = 1'b0;
    step();
    chk("t4_wrap_valid", 32'(out_valid), 32'h1);
    chk("t4_wrap_pdest", 32'(out_pdest[5:0]), 32'h1E);
    // asynchronous reset with slots pending and a broadcast in flight
    set_req(0, 2'd0, 6'h01, 1'b0, 5'd1);
    for (int i = 1; i < 4; i++) set_req(i, 2'd3, 6'(6'h20 + i), 1'b0, 5'(i));
    step();
    clear_reqs();
    step();
    chk("t5_pre_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("t5_async_valid", 32'(out_valid), 32'h0);
    chk("t5_async_pdest", 32'(out_pdest), 32'h0);
    chk("t5_async_ready", 32'(ready), 32'hF);
    @(negedge clock);
    reset = 1'b0;
    seen = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      seen |= out_valid;
    end
    chk("t5_no_bcast", 32'(seen), 32'h0);
`ifdef WAKEUP_SCHED_PERF_EN
    // four mature slots against two ports: two stall for one cycle
    do_reset();
    chk("perf_rst", perf_stall, 32'h0);
    for (int i = 0; i < 4; i++) set_req(i, 2'd0, 6'(i), 1'b0, 5'(i));
    step();
    clear_reqs();
    chk("perf_c1", perf_stall, 32'h0);
    step();
    chk("perf_c2", perf_stall, 32'h2);
    step();
    chk("perf_c3", perf_stall, 32'h2);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
